// File: rtl/priority_request_encoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_request_encoder
// Description : Registered priority encoder with a sticky pending register,
//               per-line masking and a valid/ready offer handshake. Selection
//               is either fixed (bit N-1 highest) or round-robin.
// Ports       : clk        - rising-edge clock
//               rstN       - asynchronous active-low reset
//               reqIn      - request pulses/levels, OR-ed into pending
//               maskIn     - 1 = line eligible for selection
//               clearIn    - synchronous flush of pending and current offer
//               readyIn    - consumer accepts the current offer
//               validOut   - codeOut holds a valid winning index
//               codeOut    - index of the offered request
//               pendingOut - pending register
//               countOut   - number of pending bits (masked or not)
// Revision    : 1.0 - initial release
// ============================================================================
module priority_request_encoder #(
    parameter  int N           = 8,
    parameter  int ROUND_ROBIN = 0,
    localparam int CODE_W      = $clog2(N)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [N-1:0]      reqIn,
    input  logic [N-1:0]      maskIn,
    input  logic              clearIn,
    input  logic              readyIn,
    output logic              validOut,
    output logic [CODE_W-1:0] codeOut,
    output logic [N-1:0]      pendingOut,
    output logic [CODE_W:0]   countOut
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic                valid_q, valid_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [N-1:0]        eligible;
    logic [N-1:0]        grant_bit;
    logic [CODE_W-1:0]   winner;
    logic [CODE_W-1:0]   lo_win;
    logic                lo_hit;
    logic [CODE_W-1:0]   hi_win;
    logic [CODE_W:0]     count;

    assign eligible = pending_q & maskIn;

    // Round-robin order is rrPtr-1 down to 0, then N-1 down to rrPtr.
    // lo_win is the highest eligible index strictly below the pointer; if
    // none exists, the highest eligible index overall lies in the wrapped
    // region and is the winner. Fixed mode (and rrPtr = 0) uses hi_win only.
    always_comb begin
        lo_win = '0;
        lo_hit = 1'b0;
        hi_win = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) begin
                hi_win = CODE_W'(i);
                if (CODE_W'(i) < rr_ptr_q) begin
                    lo_win = CODE_W'(i);
                    lo_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        winner = hi_win;
        if ((ROUND_ROBIN != 0) && lo_hit) begin
            winner = lo_win;
        end
    end

    // One-hot of the offered index, only when the handshake completes.
    always_comb begin
        grant_bit = '0;
        for (int i = 0; i < N; i++) begin
            grant_bit[i] = valid_q && readyIn && (code_q == CODE_W'(i));
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + {{CODE_W{1'b0}}, pending_q[i]};
        end
    end

    // Next-state logic. The OR with reqIn comes after the grant clear so a
    // request arriving on the line granted this cycle re-arms it.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        code_d    = code_q;
        rr_ptr_d  = rr_ptr_q;
        pending_d = (pending_q & ~grant_bit) | reqIn;

        if (clearIn) begin
            pending_d = '0;
            valid_d   = 1'b0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|eligible) begin
                        code_d  = winner;
                        valid_d = 1'b1;
                        state_d = ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    // The offer is held stable until accepted.
                    if (readyIn) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                        if (ROUND_ROBIN != 0) begin
                            rr_ptr_d = code_q;
                        end
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign validOut   = valid_q;
    assign codeOut    = code_q;
    assign pendingOut = pending_q;
    assign countOut   = count;

endmodule
`default_nettype wire

// File: tb/tb_priority_request_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_request_encoder
// Description : Self-checking bench for priority_request_encoder. A fixed-
//               priority and a round-robin instance share all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_request_encoder;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] reqIn;
    logic [7:0] maskIn;
    logic       clearIn;
    logic       readyIn;

    logic       f_valid, r_valid;
    logic [2:0] f_code,  r_code;
    logic [7:0] f_pend,  r_pend;
    logic [3:0] f_cnt,   r_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    priority_request_encoder #(.N(N), .ROUND_ROBIN(0)) u_fixed (
        .clk(clk), .rstN(rstN), .reqIn(reqIn), .maskIn(maskIn),
        .clearIn(clearIn), .readyIn(readyIn), .validOut(f_valid),
        .codeOut(f_code), .pendingOut(f_pend), .countOut(f_cnt)
    );

    priority_request_encoder #(.N(N), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rstN(rstN), .reqIn(reqIn), .maskIn(maskIn),
        .clearIn(clearIn), .readyIn(readyIn), .validOut(r_valid),
        .codeOut(r_code), .pendingOut(r_pend), .countOut(r_cnt)
    );

    // ---------------- behavioural reference (index 0 fixed, 1 round-robin)
    logic [7:0] m_pend  [2];
    logic       m_valid [2];
    logic [2:0] m_code  [2];
    logic [2:0] m_ptr   [2];

    function automatic logic [2:0] pick(input logic [7:0] elig, input logic [2:0] ptr);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = (int'(ptr) + 8 - k) % 8;
            if (elig[idx]) return idx[2:0];
        end
        return 3'd0;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_valid[m] = 1'b0; m_code[m] = '0; m_ptr[m] = '0;
        end
    endfunction

    function automatic void model_step();
        logic [7:0] nxt;
        for (int m = 0; m < 2; m++) begin
            if (clearIn) begin
                m_pend[m]  = '0;
                m_valid[m] = 1'b0;
            end else begin
                nxt = m_pend[m];
                if (m_valid[m] && readyIn) nxt[m_code[m]] = 1'b0;
                nxt = nxt | reqIn;
                if (m_valid[m]) begin
                    if (readyIn) begin
                        m_valid[m] = 1'b0;
                        if (m == 1) m_ptr[m] = m_code[m];
                    end
                end else if ((m_pend[m] & maskIn) != 8'h00) begin
                    m_code[m]  = pick(m_pend[m] & maskIn, (m == 1) ? m_ptr[m] : 3'd0);
                    m_valid[m] = 1'b1;
                end
                m_pend[m] = nxt;
            end
        end
    endfunction

    // Advance one clock: reference follows the edge, outputs settle by +1.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_clear();
        clearIn = 1'b1; reqIn = '0; readyIn = 1'b0; maskIn = 8'hFF;
        step();
        clearIn = 1'b0;
    endtask

    // ---------------- tests
    task automatic test_reset();
        rstN = 1'b0; reqIn = '0; maskIn = 8'hFF; clearIn = 1'b0; readyIn = 1'b0;
        model_reset();
        #12;
        total_cnt++;
        if ({f_valid, f_code, f_pend, f_cnt} !== 16'h0)
            $display("FAIL reset_fixed: got v=%0b c=%0d p=%h n=%0d want all 0", f_valid, f_code, f_pend, f_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({r_valid, r_code, r_pend, r_cnt} !== 16'h0)
            $display("FAIL reset_rr: got v=%0b c=%0d p=%h n=%0d want all 0", r_valid, r_code, r_pend, r_cnt);
        else pass_cnt++;
        rstN = 1'b1;
        step();
    endtask

    task automatic test_fixed_order();
        logic [2:0] codes[$];
        logic [3:0] cnts[$];
        logic [2:0] exp_c [3] = '{3'd4, 3'd2, 3'd1};
        logic [3:0] exp_n [3] = '{4'd3, 4'd2, 4'd1};
        do_clear();
        readyIn = 1'b1; reqIn = 8'b0001_0110;
        step();
        reqIn = '0;
        repeat (10) begin
            if (f_valid) begin codes.push_back(f_code); cnts.push_back(f_cnt); end
            step();
        end
        total_cnt++;
        if (codes.size() != 3) $display("FAIL fixed_grant_count: got %0d want 3", codes.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < codes.size(); i++) begin
            total_cnt++;
            if (codes[i] !== exp_c[i] || cnts[i] !== exp_n[i])
                $display("FAIL fixed_offer%0d: got code=%0d cnt=%0d want code=%0d cnt=%0d", i, codes[i], cnts[i], exp_c[i], exp_n[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (f_valid !== 1'b0 || f_cnt !== 4'd0)
            $display("FAIL fixed_drained: got v=%0b n=%0d want v=0 n=0", f_valid, f_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [2:0] codes[$];
        logic [2:0] exp_c [3] = '{3'd1, 3'd7, 3'd0};
        do_clear();
        reqIn = 8'h03;
        step();
        reqIn = '0;
        step();
        repeat (3) step();
        total_cnt++;
        if (f_valid !== 1'b1 || f_code !== 3'd1)
            $display("FAIL bp_hold: got v=%0b c=%0d want v=1 c=1", f_valid, f_code);
        else pass_cnt++;
        reqIn = 8'h80;
        step();
        reqIn = '0;
        repeat (2) step();
        total_cnt++;
        if (f_valid !== 1'b1 || f_code !== 3'd1 || f_pend !== 8'h83)
            $display("FAIL bp_no_preempt: got v=%0b c=%0d p=%h want v=1 c=1 p=83", f_valid, f_code, f_pend);
        else pass_cnt++;
        readyIn = 1'b1;
        repeat (8) begin
            if (f_valid) codes.push_back(f_code);
            step();
        end
        total_cnt++;
        if (codes.size() != 3) $display("FAIL bp_grant_count: got %0d want 3", codes.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < codes.size(); i++) begin
            total_cnt++;
            if (codes[i] !== exp_c[i]) $display("FAIL bp_grant%0d: got %0d want %0d", i, codes[i], exp_c[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_mask();
        logic [2:0] codes[$];
        do_clear();
        maskIn = 8'h7F; readyIn = 1'b1; reqIn = 8'h81;
        step();
        reqIn = '0;
        repeat (6) begin
            if (f_valid) codes.push_back(f_code);
            step();
        end
        total_cnt++;
        if (codes.size() != 1 || codes[0] !== 3'd0)
            $display("FAIL mask_grants: got %0d grants first=%0d want 1 grant of 0", codes.size(), (codes.size() > 0) ? codes[0] : 3'd0);
        else pass_cnt++;
        total_cnt++;
        if (f_pend !== 8'h80 || f_cnt !== 4'd1 || f_valid !== 1'b0)
            $display("FAIL mask_kept: got p=%h n=%0d v=%0b want p=80 n=1 v=0", f_pend, f_cnt, f_valid);
        else pass_cnt++;
        maskIn = 8'hFF; readyIn = 1'b0;
        step();
        total_cnt++;
        if (f_valid !== 1'b1 || f_code !== 3'd7)
            $display("FAIL mask_release: got v=%0b c=%0d want v=1 c=7", f_valid, f_code);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [2:0] fc[$];
        logic [2:0] rc[$];
        logic [2:0] exp_r [6] = '{3'd7, 3'd4, 3'd0, 3'd7, 3'd4, 3'd0};
        // Fresh reset so the rotating pointer starts at 0.
        #2 rstN = 1'b0;
        model_reset();
        #1 rstN = 1'b1;
        reqIn = 8'b1001_0001; maskIn = 8'hFF; readyIn = 1'b1; clearIn = 1'b0;
        repeat (20) begin
            if (f_valid) fc.push_back(f_code);
            if (r_valid) rc.push_back(r_code);
            step();
        end
        reqIn = '0;
        total_cnt++;
        if (fc.size() < 6 || rc.size() < 6)
            $display("FAIL rr_grant_count: got fixed=%0d rr=%0d want >=6 each", fc.size(), rc.size());
        else pass_cnt++;
        for (int i = 0; i < 6 && i < rc.size() && i < fc.size(); i++) begin
            total_cnt++;
            if (rc[i] !== exp_r[i] || fc[i] !== 3'd7)
                $display("FAIL rr_grant%0d: got rr=%0d fixed=%0d want rr=%0d fixed=7", i, rc[i], fc[i], exp_r[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_collision();
        do_clear();
        reqIn = 8'h20;
        step();
        reqIn = '0;
        step();
        total_cnt++;
        if (f_valid !== 1'b1 || f_code !== 3'd5)
            $display("FAIL coll_offer: got v=%0b c=%0d want v=1 c=5", f_valid, f_code);
        else pass_cnt++;
        readyIn = 1'b1; reqIn = 8'h20;
        step();
        readyIn = 1'b0; reqIn = '0;
        total_cnt++;
        if (f_pend !== 8'h20 || f_valid !== 1'b0)
            $display("FAIL coll_rearm: got p=%h v=%0b want p=20 v=0", f_pend, f_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (f_valid !== 1'b1 || f_code !== 3'd5)
            $display("FAIL coll_reoffer: got v=%0b c=%0d want v=1 c=5", f_valid, f_code);
        else pass_cnt++;
        clearIn = 1'b1; reqIn = 8'h08;
        step();
        clearIn = 1'b0; reqIn = '0;
        total_cnt++;
        if (f_valid !== 1'b0 || f_pend !== 8'h00 || r_valid !== 1'b0 || r_pend !== 8'h00)
            $display("FAIL coll_clear: got fv=%0b fp=%h rv=%0b rp=%h want all 0", f_valid, f_pend, r_valid, r_pend);
        else pass_cnt++;
    endtask

    task automatic test_reset_midoffer();
        do_clear();
        reqIn = 8'h24;
        step();
        reqIn = '0;
        step();
        total_cnt++;
        if (f_valid !== 1'b1 || f_code !== 3'd5)
            $display("FAIL midrst_offer: got v=%0b c=%0d want v=1 c=5", f_valid, f_code);
        else pass_cnt++;
        #2 rstN = 1'b0;
        model_reset();
        #1;
        total_cnt++;
        if ({f_valid, f_code, f_pend} !== 12'h0 || {r_valid, r_code, r_pend} !== 12'h0)
            $display("FAIL midrst_async: got fv=%0b fc=%0d fp=%h rv=%0b rc=%0d rp=%h want all 0",
                     f_valid, f_code, f_pend, r_valid, r_code, r_pend);
        else pass_cnt++;
        #4 rstN = 1'b1;
        reqIn = 8'h42; readyIn = 1'b1;
        step();
        reqIn = '0;
        step();
        total_cnt++;
        if (f_valid !== 1'b1 || f_code !== 3'd6 || r_valid !== 1'b1 || r_code !== 3'd6)
            $display("FAIL midrst_first: got fv=%0b fc=%0d rv=%0b rc=%0d want v=1 c=6 both",
                     f_valid, f_code, r_valid, r_code);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [3:0] exp_n;
        do_clear();
        for (int t = 0; t < 600; t++) begin
            reqIn   = 8'($urandom & $urandom & $urandom);
            maskIn  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            readyIn = ($urandom_range(0, 3) != 0);
            clearIn = ($urandom_range(0, 63) == 0);
            step();
            exp_n = 4'($countones(m_pend[0]));
            total_cnt++;
            if ({f_valid, f_code, f_pend, f_cnt} !== {m_valid[0], m_code[0], m_pend[0], exp_n})
                $display("FAIL rand_fixed t=%0d: got v=%0b c=%0d p=%h n=%0d want v=%0b c=%0d p=%h n=%0d",
                         t, f_valid, f_code, f_pend, f_cnt, m_valid[0], m_code[0], m_pend[0], exp_n);
            else pass_cnt++;
            exp_n = 4'($countones(m_pend[1]));
            total_cnt++;
            if ({r_valid, r_code, r_pend, r_cnt} !== {m_valid[1], m_code[1], m_pend[1], exp_n})
                $display("FAIL rand_rr t=%0d: got v=%0b c=%0d p=%h n=%0d want v=%0b c=%0d p=%h n=%0d",
                         t, r_valid, r_code, r_pend, r_cnt, m_valid[1], m_code[1], m_pend[1], exp_n);
            else pass_cnt++;
        end
        clearIn = 1'b0; reqIn = '0;
    endtask

    initial begin
        test_reset();
        test_fixed_order();
        test_backpressure();
        test_mask();
        test_round_robin();
        test_collision();
        test_reset_midoffer();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
